// File: rtl/argmax_top2_if.sv
// rtl/argmax_top2_if.sv - request/result bundle for the argmax_top2 scanner
interface argmax_top2_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DIM        = 10,
   parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
);
   logic                              start;
   logic                              mode_min;
   logic [DIM-1:0][DATA_WIDTH-1:0]    vec;
   logic                              busy;
   logic                              done;
   logic [IDXW-1:0]                   idx;
   logic [IDXW-1:0]                   idx2;
   logic signed [DATA_WIDTH-1:0]      best;
   logic [DATA_WIDTH-1:0]             margin;

   modport master (
      output start, mode_min, vec,
      input  busy, done, idx, idx2, best, margin
   );

   modport slave (
      input  start, mode_min, vec,
      output busy, done, idx, idx2, best, margin
   );
endinterface

// File: rtl/argmax_top2.sv
// rtl/argmax_top2.sv - multi-lane argmax/argmin scanner reporting winner, runner-up and margin
module argmax_top2 #(
   parameter int DATA_WIDTH = 16,
   parameter int DIM        = 10,
   parameter int LANES      = 1,
   parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
   input logic          clk,
   input logic          reset,
   argmax_top2_if.slave bus
);
   localparam int BEATS = (DIM + LANES - 1) / LANES;
   localparam int SLOTS = BEATS * LANES;
   localparam int BW    = (BEATS <= 1) ? 1 : $clog2(BEATS);
   localparam int EW    = (SLOTS <= 1) ? 1 : $clog2(SLOTS);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                       state, state_n;
   logic [BW-1:0]                beat, beat_n, cur_beat;
   logic                         mode_q, mode_n, cur_mode;
   logic signed [DATA_WIDTH-1:0] win_val, win_val_n, run_val, run_val_n;
   logic [IDXW-1:0]              win_idx, win_idx_n, run_idx, run_idx_n;
   logic                         run_vld, run_vld_n;
   logic                         done_q, done_n;
   logic [IDXW-1:0]              idx_q, idx_n, idx2_q, idx2_n;
   logic signed [DATA_WIDTH-1:0] best_q, best_n;
   logic [DATA_WIDTH-1:0]        margin_q, margin_n;

   logic signed [DATA_WIDTH-1:0] cw, rv, e;
   logic [IDXW-1:0]              ci, ri;
   logic                         rvld, last, advance;
   logic [DATA_WIDTH-1:0]        gap;
   int                           pos;

   // Zero-padded view so the final partial beat can be indexed uniformly.
   logic signed [DATA_WIDTH-1:0] elem [SLOTS];

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      if (g < DIM) begin : g_real
         assign elem[g] = bus.vec[g];
      end else begin : g_pad
         assign elem[g] = '0;
      end
   end

   function automatic logic better(input logic signed [DATA_WIDTH-1:0] a,
                                   input logic signed [DATA_WIDTH-1:0] b,
                                   input logic mn);
      return mn ? (a < b) : (a > b);
   endfunction

   always_comb begin
      state_n   = state;
      beat_n    = beat;
      mode_n    = mode_q;
      win_val_n = win_val;
      win_idx_n = win_idx;
      run_val_n = run_val;
      run_idx_n = run_idx;
      run_vld_n = run_vld;
      done_n    = 1'b0;
      idx_n     = idx_q;
      idx2_n    = idx2_q;
      best_n    = best_q;
      margin_n  = margin_q;
      pos       = 0;
      e         = '0;

      // Beat 0 is folded in the start cycle itself so done lands BEATS cycles after start.
      if (state == RUN) begin
         cur_beat = beat;
         cur_mode = mode_q;
         cw       = win_val;
         ci       = win_idx;
         rv       = run_val;
         ri       = run_idx;
         rvld     = run_vld;
      end else begin
         cur_beat = '0;
         cur_mode = bus.mode_min;
         cw       = elem[0];
         ci       = '0;
         rv       = '0;
         ri       = '0;
         rvld     = 1'b0;
      end

      for (int l = 0; l < LANES; l++) begin
         pos = int'(cur_beat) * LANES + l;
         if (pos < DIM && pos != 0) begin
            e = elem[pos[EW-1:0]];
            if (better(e, cw, cur_mode)) begin
               rv   = cw;
               ri   = ci;
               rvld = 1'b1;
               cw   = e;
               ci   = pos[IDXW-1:0];
            end else if (!rvld || better(e, rv, cur_mode)) begin
               rv   = e;
               ri   = pos[IDXW-1:0];
               rvld = 1'b1;
            end
         end
      end

      // The true difference is non-negative and below 2^DATA_WIDTH, so the wrapped low bits are exact.
      gap     = cur_mode ? DATA_WIDTH'(rv - cw) : DATA_WIDTH'(cw - rv);
      last    = (cur_beat == BW'(BEATS - 1));
      advance = (state == RUN) || bus.start;

      if (advance) begin
         mode_n = cur_mode;
         if (last) begin
            state_n  = IDLE;
            beat_n   = '0;
            done_n   = 1'b1;
            idx_n    = ci;
            idx2_n   = rvld ? ri : '0;
            best_n   = cw;
            margin_n = rvld ? gap : '0;
         end else begin
            state_n   = RUN;
            beat_n    = (state == RUN) ? beat + BW'(1) : BW'(1);
            win_val_n = cw;
            win_idx_n = ci;
            run_val_n = rv;
            run_idx_n = ri;
            run_vld_n = rvld;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         beat     <= '0;
         mode_q   <= 1'b0;
         win_val  <= '0;
         win_idx  <= '0;
         run_val  <= '0;
         run_idx  <= '0;
         run_vld  <= 1'b0;
         done_q   <= 1'b0;
         idx_q    <= '0;
         idx2_q   <= '0;
         best_q   <= '0;
         margin_q <= '0;
      end else begin
         state    <= state_n;
         beat     <= beat_n;
         mode_q   <= mode_n;
         win_val  <= win_val_n;
         win_idx  <= win_idx_n;
         run_val  <= run_val_n;
         run_idx  <= run_idx_n;
         run_vld  <= run_vld_n;
         done_q   <= done_n;
         idx_q    <= idx_n;
         idx2_q   <= idx2_n;
         best_q   <= best_n;
         margin_q <= margin_n;
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = done_q;
   assign bus.idx    = idx_q;
   assign bus.idx2   = idx2_q;
   assign bus.best   = best_q;
   assign bus.margin = margin_q;
endmodule

// File: tb/tb_argmax_top2.sv
// tb/tb_argmax_top2.sv - directed vector bench over four argmax_top2 configurations
module tb_argmax_top2;
   logic clk;
   logic reset;

   logic [3:0]         start_v, mode_v, done_v, busy_v;
   logic [3:0]         idx_v   [4];
   logic [3:0]         idx2_v  [4];
   logic signed [15:0] best_v  [4];
   logic [15:0]        margin_v[4];
   logic [9:0][15:0]   vec10;
   logic [0:0][15:0]   vec1;

   int passed = 0;
   int total  = 0;

   argmax_top2_if #(.DATA_WIDTH(16), .DIM(10)) bus_a ();
   argmax_top2_if #(.DATA_WIDTH(16), .DIM(10)) bus_b ();
   argmax_top2_if #(.DATA_WIDTH(16), .DIM(10)) bus_c ();
   argmax_top2_if #(.DATA_WIDTH(16), .DIM(1))  bus_d ();

   argmax_top2 #(.DATA_WIDTH(16), .DIM(10), .LANES(4)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
   argmax_top2 #(.DATA_WIDTH(16), .DIM(10), .LANES(1)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
   argmax_top2 #(.DATA_WIDTH(16), .DIM(10), .LANES(3)) u_c (.clk(clk), .reset(reset), .bus(bus_c));
   argmax_top2 #(.DATA_WIDTH(16), .DIM(1),  .LANES(1)) u_d (.clk(clk), .reset(reset), .bus(bus_d));

   assign bus_a.start = start_v[0];  assign bus_a.mode_min = mode_v[0];  assign bus_a.vec = vec10;
   assign bus_b.start = start_v[1];  assign bus_b.mode_min = mode_v[1];  assign bus_b.vec = vec10;
   assign bus_c.start = start_v[2];  assign bus_c.mode_min = mode_v[2];  assign bus_c.vec = vec10;
   assign bus_d.start = start_v[3];  assign bus_d.mode_min = mode_v[3];  assign bus_d.vec = vec1;

   assign done_v = {bus_d.done, bus_c.done, bus_b.done, bus_a.done};
   assign busy_v = {bus_d.busy, bus_c.busy, bus_b.busy, bus_a.busy};
   assign idx_v[0] = bus_a.idx;   assign idx2_v[0] = bus_a.idx2;
   assign idx_v[1] = bus_b.idx;   assign idx2_v[1] = bus_b.idx2;
   assign idx_v[2] = bus_c.idx;   assign idx2_v[2] = bus_c.idx2;
   assign idx_v[3] = {3'b000, bus_d.idx};  assign idx2_v[3] = {3'b000, bus_d.idx2};
   assign best_v[0] = bus_a.best; assign margin_v[0] = bus_a.margin;
   assign best_v[1] = bus_b.best; assign margin_v[1] = bus_b.margin;
   assign best_v[2] = bus_c.best; assign margin_v[2] = bus_c.margin;
   assign best_v[3] = bus_d.best; assign margin_v[3] = bus_d.margin;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int               sel;
      logic             mode;
      logic [9:0][15:0] v;
      int               e_lat;
      int               e_idx;
      int               e_idx2;
      int               e_best;
      int               e_margin;
   } vec_t;

   vec_t tbl[$];
   int   beats_of[4] = '{3, 10, 4, 1};

   function automatic logic [9:0][15:0] mk(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7,
                                           input int a8, input int a9);
      return {a9[15:0], a8[15:0], a7[15:0], a6[15:0], a5[15:0],
              a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
   endfunction

   task automatic add(input int sel, input logic mode, input logic [9:0][15:0] v,
                      input int e_idx, input int e_idx2, input int e_best, input int e_margin);
      vec_t t;
      t.sel = sel; t.mode = mode; t.v = v; t.e_lat = beats_of[sel];
      t.e_idx = e_idx; t.e_idx2 = e_idx2; t.e_best = e_best; t.e_margin = e_margin;
      tbl.push_back(t);
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Start in cycle 0, optionally hold start for 'extra' more cycles (with mode flipped).
   task automatic run_one(input int sel, input logic m, input logic [9:0][15:0] v, input int extra,
                          output int lat, output int busy_bad);
      vec10 = v;
      vec1[0] = v[0];
      @(posedge clk); #1;
      start_v[sel] = 1'b1;
      mode_v[sel]  = m;
      lat = -1;
      busy_bad = 0;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         @(negedge clk);
         if (busy_v[sel] !== (c >= 1 && c < beats_of[sel])) busy_bad++;
         if (done_v[sel] === 1'b1) lat = c;
         @(posedge clk); #1;
         start_v[sel] = (c + 1 <= extra);
         mode_v[sel]  = (c + 1 <= extra) ? ~m : m;
      end
      start_v[sel] = 1'b0;
   endtask

   task automatic check_run(input string tag, input int sel, input int lat, input int busy_bad,
                            input int e_lat, input int e_idx, input int e_idx2,
                            input int e_best, input int e_margin);
      @(negedge clk);
      check({tag, " latency"},    lat, e_lat);
      check({tag, " busy"},       busy_bad, 0);
      check({tag, " idx"},        int'(idx_v[sel]), e_idx);
      check({tag, " idx2"},       int'(idx2_v[sel]), e_idx2);
      check({tag, " best"},       int'(best_v[sel]), e_best);
      check({tag, " margin"},     int'(margin_v[sel]), e_margin);
      check({tag, " done pulse"}, int'(done_v[sel]), 0);
   endtask

   initial begin
      int lat, bb, cnt;
      logic [9:0][15:0] v1, v6;

      reset = 1'b0;
      start_v = '0;
      mode_v = '0;
      vec10 = '0;
      vec1 = '0;

      v1 = mk(3, -7, 12, 0, 5, 12, -1, 9, 2, 4);
      v6 = mk(5, 4, 3, 2, 1, 0, 1, 2, 3, -3);
      add(0, 1'b0, v1, 2, 5, 12, 0);
      add(0, 1'b1, v1, 1, 6, -7, 6);
      add(1, 1'b0, mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768),
          0, 1, -32768, 0);
      add(2, 1'b0, mk(-32768, -32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768, -32768),
          4, 0, 32767, 65535);
      add(2, 1'b1, mk(-32768, -32768, -32768, -32768, 32767, -32768, -32768, -32768, -32768, -32768),
          0, 1, -32768, 0);
      add(0, 1'b0, mk(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10), 0, 1, -1, 1);
      add(0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 100), 9, 0, 100, 100);
      add(0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 100), 0, 1, 0, 0);
      add(0, 1'b1, v6, 9, 5, -3, 3);
      add(1, 1'b0, v1, 2, 5, 12, 0);
      add(2, 1'b1, v6, 9, 5, -3, 3);
      add(3, 1'b0, mk(-5, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, -5, 0);

      #12;
      check("reset busy",   int'(busy_v), 0);
      check("reset done",   int'(done_v), 0);
      check("reset idx",    int'(idx_v[0]), 0);
      check("reset best",   int'(best_v[0]), 0);
      check("reset margin", int'(margin_v[3]), 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         run_one(tbl[i].sel, tbl[i].mode, tbl[i].v, 0, lat, bb);
         check_run($sformatf("vec%0d", i), tbl[i].sel, lat, bb, tbl[i].e_lat,
                   tbl[i].e_idx, tbl[i].e_idx2, tbl[i].e_best, tbl[i].e_margin);
      end

      // Extra starts during a run must neither restart it nor follow it with another run.
      run_one(0, 1'b0, v1, 2, lat, bb);
      check_run("restart", 0, lat, bb, 3, 2, 5, 12, 0);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         cnt += int'(done_v[0]) + int'(busy_v[0]);
      end
      check("restart idle", cnt, 0);
      check("restart hold idx", int'(idx_v[0]), 2);

      // Reset in cycle 2 of a run: immediate clear, no done.
      vec10 = v6;
      @(posedge clk); #1;
      start_v[0] = 1'b1;
      mode_v[0]  = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      check("abort busy before", int'(busy_v[0]), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort busy",   int'(busy_v[0]), 0);
      check("abort done",   int'(done_v[0]), 0);
      check("abort idx",    int'(idx_v[0]), 0);
      check("abort idx2",   int'(idx2_v[0]), 0);
      check("abort best",   int'(best_v[0]), 0);
      check("abort margin", int'(margin_v[0]), 0);
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         cnt += int'(done_v[0]);
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         cnt += int'(done_v[0]);
      end
      check("abort no done", cnt, 0);

      run_one(0, 1'b1, v6, 0, lat, bb);
      check_run("after abort", 0, lat, bb, 3, 9, 5, -3, 3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/argmax_top2.md
Name: argmax_top2

Overview:
Parametrised successor to the single-compare argmax scanner in the classifier back end. It scans a signed logit vector LANES elements per cycle and returns the winning index and value, the runner-up index, and the unsigned margin between the two, which serves as a confidence measure. A per-run mode selects max or min search. It sits after the final dense layer and feeds the result/UART reporting logic.

Parameters:
DATA_WIDTH, 16, signed element width
DIM, 10, vector length, >= 1
LANES, 1, elements compared per cycle, 1..DIM
IDXW, (DIM<=1)?1:$clog2(DIM), index width
BEATS, ceil(DIM/LANES) (derived localparam, not overridable), RUN cycles per search

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  request a search; sampled only in IDLE
mode_min  in  1  0 = argmax, 1 = argmin; latched with start
vec  in  DIM x DATA_WIDTH signed  input vector; must be held stable from the start cycle through done
busy  out  1  high while a search is in progress
done  out  1  one-cycle pulse when results update
idx  out  IDXW  winning index
idx2  out  IDXW  runner-up index
best  out  DATA_WIDTH signed  winning value
margin  out  DATA_WIDTH unsigned  |best - runner-up|

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, idx=0, idx2=0, best=0, margin=0; internal beat counter=0.
- States: IDLE, RUN.
- IDLE: start=1 -> latch mode_min, initialise winner = vec[0]/index 0, runner-up = none (invalid flag), beat=0, go to RUN, busy=1. start=0 -> stay.
- RUN beat b covers elements b*LANES .. min(b*LANES+LANES-1, DIM-1). Lanes past DIM-1 on the last beat are ignored. Element 0 is skipped on beat 0, since it is already seeded. Elements are folded in ascending index order within a beat, combinationally.
- Fold rule for element e at index j ("better" means > in max mode, < in min mode; all comparisons signed):
  - e better than winner -> runner-up := winner; winner := (e, j).
  - Otherwise, if runner-up invalid or e better than runner-up -> runner-up := (e, j).
  - Ties never displace: the lowest index wins among equal values for both winner and runner-up.
- Last beat (b == BEATS-1): register idx, best, idx2, margin; done=1 for that following cycle; busy=0; return to IDLE.
- Latency: start high in cycle 0 -> done high in cycle BEATS. busy is high in cycles 1..BEATS-1, and low in cycle BEATS. A new start is accepted in cycle BEATS.
- margin: max mode = best - runner-up; min mode = runner-up - best. Compute in DATA_WIDTH+1 bits; the result is non-negative and < 2^DATA_WIDTH, so it is truncated to DATA_WIDTH unsigned.
- DIM==1: BEATS=1, and the single RUN beat folds nothing. Result: idx=0, idx2=0, best=vec[0], margin=0.
- start while busy is ignored; the current run is unaffected. mode_min is ignored outside the start cycle.
- Outputs other than done hold their last result until the next done.
- Reset asserted mid-run: immediate abort to reset values. No done is issued for the aborted run.
- vec changing during RUN is undefined use. No checking is required.

Test Plan:
- DIM=10, LANES=4, max, vec={3,-7,12,0,5,12,-1,9,2,4}, start in cycle 0 -> done in cycle 3; idx=2, best=12, idx2=5, margin=0 (tie, lowest index wins).
- Same vec, mode_min=1 -> idx=1, best=-7, idx2=6, margin=6.
- DIM=10, LANES=1, vec all 16'sh8000 -> done in cycle 10; idx=0, idx2=1, margin=0. Pulse lasts exactly one cycle and busy drops the same cycle.
- Extremes, LANES=3: vec[4]=32767, vec[8]=-32768, rest -32768 -> idx=4, idx2=0, margin=65535 (no overflow). With mode_min=1 -> idx=0, idx2=1, margin=0.
- Start pulsed again in cycles 1-2 of a run, then reset driven low in cycle 2 of a second run -> first run's results unchanged by the extra starts; second run produces no done, all outputs return to 0 asynchronously, and a fresh start after release completes normally.
- DIM=1, LANES=1, vec[0]=-5 -> done in cycle 1; idx=0, idx2=0, best=-5, margin=0.
